// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired fetch/decode/execute controller for a simple register-to-register
// datapath. One instruction takes six or more timing steps:
//
//   T0  PC -> MAR, PC+1 -> Z
//   T1  Z -> PC, start memory read into MDR (held until MemReady)
//   T2  MDR -> IR
//   T3  decode: first operand (Rb) -> Y, or flag illegal, or halt
//   T4  second operand (Rc, or Rb for unary ops) -> ALU, result -> Z
//   T5  Z -> Ra
//
// The outputs are a function of the current state and the IR only. They have
// no output registers, so forcing the state to IDLE also forces every output
// low in the same instant.
//
// Ports
//   clock     in   sole clock, rising edge
//   clear     in   asynchronous active-low reset (state -> IDLE)
//   Start     in   leave IDLE and begin fetching (ignored elsewhere)
//   MemReady  in   memory read data valid this cycle (looked at in T1 only)
//   IR        in   [31:0] instruction register contents from the datapath
//   Rin       out  [15:0] one-hot register load enable
//   Rout      out  [15:0] one-hot register bus drive enable
//   PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout,
//   IncPC, Read
//             out  datapath control strobes
//   ALUop     out  [3:0] ALU operation select (non-zero only in T4)
//   Run       out  high while an instruction is in progress (T0..T5)
//   Illegal   out  one-cycle pulse in T3 for an undefined opcode
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        Start,
    input  logic        MemReady,
    input  logic [31:0] IR,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        IncPC,
    output logic        Read,
    output logic [3:0]  ALUop,
    output logic        Run,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t state_reg;
    state_t state_next;

    // -----------------------------------------------------------------------
    // Instruction field extraction and opcode classification
    // -----------------------------------------------------------------------
    logic [4:0]  opcode;
    logic [3:0]  ra_field;
    logic [3:0]  rb_field;
    logic [3:0]  rc_field;
    logic        op_binary;
    logic        op_unary;
    logic        op_halt;
    logic [15:0] ra_onehot;
    logic [15:0] rb_onehot;
    logic [15:0] rc_onehot;

    assign opcode   = IR[31:27];
    assign ra_field = IR[26:23];
    assign rb_field = IR[22:19];
    assign rc_field = IR[18:15];

    // Opcodes 0..8 take two register operands; 9 (neg) and 10 (not) take one.
    assign op_binary = (opcode <= 5'd8);
    assign op_unary  = (opcode == 5'd9) || (opcode == 5'd10);
    assign op_halt   = (opcode == 5'h1F);

    // The low IR bits are immediate/unused space in this instruction set.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];

    // Register-number to one-hot decoders. Each output bit is a simple
    // equality compare, so at most one bit can ever be set per decoder.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_reg_decode
            assign ra_onehot[gi] = (ra_field == 4'(gi));
            assign rb_onehot[gi] = (rb_field == 4'(gi));
            assign rc_onehot[gi] = (rc_field == 4'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        Rin        = 16'h0000;
        Rout       = 16'h0000;
        PCin       = 1'b0;
        PCout      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zlowout    = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        ALUop      = 4'h0;
        Run        = 1'b0;
        Illegal    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_T0;
                end
            end

            S_T0: begin
                Run        = 1'b1;
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zlowin     = 1'b1;
                state_next = S_T1;
            end

            S_T1: begin
                // Reloading PC from Z on every wait cycle is harmless: Z still
                // holds PC+1 from T0, so the strobes can stay constant here.
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (MemReady) begin
                    state_next = S_T2;
                end
            end

            S_T2: begin
                Run        = 1'b1;
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end

            S_T3: begin
                Run = 1'b1;
                if (op_binary) begin
                    Rout       = rb_onehot;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else if (op_unary) begin
                    // Unary ops need no Y operand; T3 is a dead step for them.
                    state_next = S_T4;
                end else if (op_halt) begin
                    state_next = S_HALT;
                end else begin
                    Illegal    = 1'b1;
                    state_next = S_T0;
                end
            end

            S_T4: begin
                Run        = 1'b1;
                Zlowin     = 1'b1;
                ALUop      = opcode[3:0];
                Rout       = op_unary ? rb_onehot : rc_onehot;
                state_next = S_T5;
            end

            S_T5: begin
                Run        = 1'b1;
                Zlowout    = 1'b1;
                Rin        = ra_onehot;
                state_next = S_T0;
            end

            S_HALT: begin
                // Terminal until clear is asserted.
                state_next = S_HALT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Drives control_sequencer with directed and randomized instructions and
// compares every cycle's outputs against an instruction-level reference:
// for each instruction the bench knows the phase sequence
// (T0, T1 x (waits+1), T2, decode, execute, writeback) and the strobes each
// phase must show, derived from the opcode class and register fields.
// Outputs are sampled on the falling edge; inputs change right after.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        Start;
    logic        MemReady;
    logic [31:0] IR;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, PCout, MARin, MDRin, MDRout, IRin, Yin;
    logic        Zlowin, Zlowout, IncPC, Read;
    logic [3:0]  ALUop;
    logic        Run;
    logic        Illegal;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        pcin;
        logic        pcout;
        logic        marin;
        logic        mdrin;
        logic        mdrout;
        logic        irin;
        logic        yin;
        logic        zlowin;
        logic        zlowout;
        logic        incpc;
        logic        read;
        logic [3:0]  aluop;
        logic        run;
        logic        illegal;
    } outs_t;

    outs_t dut_outs;
    assign dut_outs = {Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
                       Zlowin, Zlowout, IncPC, Read, ALUop, Run, Illegal};

    int n_checks   = 0;
    int n_failures = 0;

    control_sequencer dut (
        .clock    (clock),
        .clear    (clear),
        .Start    (Start),
        .MemReady (MemReady),
        .IR       (IR),
        .Rin      (Rin),
        .Rout     (Rout),
        .PCin     (PCin),
        .PCout    (PCout),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zlowin   (Zlowin),
        .Zlowout  (Zlowout),
        .IncPC    (IncPC),
        .Read     (Read),
        .ALUop    (ALUop),
        .Run      (Run),
        .Illegal  (Illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference: expected outputs per instruction phase -----
    function automatic outs_t exp_zero();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t exp_fetch_addr();
        outs_t o = '0;
        o.run = 1; o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
        return o;
    endfunction

    function automatic outs_t exp_fetch_read();
        outs_t o = '0;
        o.run = 1; o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1;
        return o;
    endfunction

    function automatic outs_t exp_fetch_ir();
        outs_t o = '0;
        o.run = 1; o.mdrout = 1; o.irin = 1;
        return o;
    endfunction

    function automatic outs_t exp_decode(input logic [31:0] ir);
        outs_t o = '0;
        int op = int'(ir[31:27]);
        int rb = int'(ir[22:19]);
        o.run = 1;
        if (op <= 8) begin
            o.rout = 16'(1 << rb);
            o.yin  = 1;
        end else if (op == 9 || op == 10 || op == 31) begin
            // no strobes
        end else begin
            o.illegal = 1;
        end
        return o;
    endfunction

    function automatic outs_t exp_execute(input logic [31:0] ir);
        outs_t o = '0;
        int op = int'(ir[31:27]);
        int rb = int'(ir[22:19]);
        int rc = int'(ir[18:15]);
        o.run    = 1;
        o.zlowin = 1;
        o.aluop  = 4'(op);
        o.rout   = (op <= 8) ? 16'(1 << rc) : 16'(1 << rb);
        return o;
    endfunction

    function automatic outs_t exp_writeback(input logic [31:0] ir);
        outs_t o = '0;
        int ra = int'(ir[26:23]);
        o.run = 1; o.zlowout = 1; o.rin = 16'(1 << ra);
        return o;
    endfunction

    function automatic logic [31:0] make_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    endfunction

    // Runs one instruction; the machine must be in T0 at the next falling edge.
    // stop_at_exec leaves it mid-instruction right after the execute step.
    task automatic do_instr(input logic [31:0] ir, input int waits, input string name,
                            input bit stop_at_exec);
        int op = int'(ir[31:27]);
        @(negedge clock);
        check_eq({name, "_t0"}, 64'(dut_outs), 64'(exp_fetch_addr()));
        IR       = $urandom;
        MemReady = 1'($urandom_range(0, 1));
        Start    = 1'($urandom_range(0, 1));
        for (int k = 0; k <= waits; k++) begin
            @(negedge clock);
            check_eq({name, "_t1"}, 64'(dut_outs), 64'(exp_fetch_read()));
            MemReady = (k == waits);
            Start    = 1'($urandom_range(0, 1));
            IR       = $urandom;
        end
        @(negedge clock);
        check_eq({name, "_t2"}, 64'(dut_outs), 64'(exp_fetch_ir()));
        IR       = ir;
        MemReady = 1'($urandom_range(0, 1));
        @(negedge clock);
        check_eq({name, "_t3"}, 64'(dut_outs), 64'(exp_decode(ir)));
        MemReady = 1'($urandom_range(0, 1));
        Start    = 1'($urandom_range(0, 1));
        if (op == 31) begin
            @(negedge clock);
            check_eq({name, "_halt"}, 64'(dut_outs), 64'(exp_zero()));
        end else if (op <= 10) begin
            @(negedge clock);
            check_eq({name, "_t4"}, 64'(dut_outs), 64'(exp_execute(ir)));
            if (!stop_at_exec) begin
                MemReady = 1'($urandom_range(0, 1));
                @(negedge clock);
                check_eq({name, "_t5"}, 64'(dut_outs), 64'(exp_writeback(ir)));
                Start = 1'($urandom_range(0, 1));
            end
        end
        $display("instr %s ir=%h op=%0d waits=%0d checks=%0d failures=%0d",
                 name, ir, op, waits, n_checks, n_failures);
    endtask

    initial begin
        clear    = 1'b0;
        Start    = 1'b0;
        MemReady = 1'b0;
        IR       = 32'h0;

        @(negedge clock);
        check_eq("reset_outs", 64'(dut_outs), 64'(exp_zero()));
        clear = 1'b1;
        // No Start: must sit in IDLE with everything low.
        for (int k = 0; k < 3; k++) begin
            MemReady = 1'($urandom_range(0, 1));
            IR       = $urandom;
            @(negedge clock);
            check_eq("idle_hold", 64'(dut_outs), 64'(exp_zero()));
        end
        Start = 1'b1;

        do_instr(32'h43820000, 0, "ror", 0);
        do_instr(make_ir(0, 1, 2, 3), 3, "add_wait3", 0);
        do_instr(make_ir(10, 2, 5, 9), 1, "not", 0);
        do_instr(make_ir(9, 15, 15, 15), 0, "neg_same", 0);
        do_instr(make_ir(12, 4, 4, 4), 2, "illegal_0c", 0);
        do_instr(make_ir(8, 0, 15, 0), 0, "ror_edge", 0);

        for (int i = 0; i < 50; i++) begin
            int op;
            if ($urandom_range(0, 5) == 0) op = $urandom_range(11, 30);
            else                           op = $urandom_range(0, 10);
            do_instr(make_ir(op, $urandom_range(0, 15), $urandom_range(0, 15),
                             $urandom_range(0, 15)),
                     $urandom_range(0, 3), "rand", 0);
        end

        // Asynchronous clear in the middle of the execute step.
        do_instr(make_ir(3, 6, 7, 8), 1, "or_abort", 1);
        #1 clear = 1'b0;
        #1 check_eq("async_clear", 64'(dut_outs), 64'(exp_zero()));
        Start = 1'b1;
        @(negedge clock);
        check_eq("clear_held", 64'(dut_outs), 64'(exp_zero()));
        Start = 1'b0;
        clear = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check_eq("post_clear_idle", 64'(dut_outs), 64'(exp_zero()));
        end
        Start = 1'b1;
        do_instr(make_ir(2, 11, 12, 13), 0, "and_restart", 0);

        // Halt, then Start pulses must not wake it.
        do_instr(make_ir(31, 0, 0, 0), 1, "halt", 0);
        for (int k = 0; k < 6; k++) begin
            Start    = 1'(k % 2);
            MemReady = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_eq("halt_hold", 64'(dut_outs), 64'(exp_zero()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have ports: clock  in  1  sole clock, all state changes on rising edge.
REQ-002 The block SHALL have ports: clear  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: Start  in  1  begin fetch/execute from IDLE; MemReady  in  1  memory read data valid on Mdatain this cycle.
REQ-004 The block SHALL have ports: IR  in  32  instruction register contents fed back from datapath.
REQ-005 The block SHALL have ports: Rin, Rout  out  16 each  one-hot register load/drive enables.
REQ-006 The block SHALL have ports: PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout, IncPC, Read  out  1 each  datapath control strobes.
REQ-007 The block SHALL have ports: ALUop  out  4  ALU operation select; Run  out  1  high while executing; Illegal  out  1  one-cycle undefined-opcode flag.

Function
REQ-008 IR fields SHALL be: opcode IR[31:27], Ra IR[26:23] (dest), Rb IR[22:19], Rc IR[18:15].
REQ-009 Opcodes 0-10 SHALL be add, sub, and, or, shr, shra, shl, rol, ror, neg, not; ALUop SHALL equal opcode[3:0] (ror=8); 5'h1F SHALL be halt; all others SHALL be illegal.
REQ-010 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALT; outputs SHALL be combinational from state and IR only (Moore plus IR decode); every strobe not listed for a state SHALL be 0.
REQ-011 IDLE: all outputs 0; Start=1 -> T0, else stay.
REQ-012 T0: PCout, MARin, IncPC, Zlowin = 1; -> T1.
REQ-013 T1: Zlowout, PCin, Read, MDRin = 1; MemReady=1 -> T2, MemReady=0 -> stay T1 with identical outputs (repeated PC reload idempotent).
REQ-014 T2: MDRout, IRin = 1; -> T3.
REQ-015 T3 decode: binary op -> Rout[Rb], Yin = 1, -> T4; neg/not -> no strobes, -> T4; halt -> HALT; illegal -> Illegal = 1, -> T0.
REQ-016 T4: binary op -> Rout[Rc], Zlowin = 1, ALUop per REQ-009; neg/not -> Rout[Rb], Zlowin = 1, ALUop per REQ-009; -> T5.
REQ-017 T5: Zlowout = 1, Rin[Ra] = 1; -> T0.
REQ-018 ALUop SHALL be 0 in every state except T4.
REQ-019 Rin and Rout SHALL never have more than one bit set; Ra=Rb=Rc legal, no special casing.
REQ-020 HALT: all outputs 0, Run = 0; exit only by reset; Start ignored.
REQ-021 Run SHALL be 1 in T0-T5, 0 in IDLE and HALT.
REQ-022 Start asserted outside IDLE SHALL be ignored.
REQ-023 MemReady SHALL be ignored outside T1.

Reset
REQ-024 clear=0 SHALL force state IDLE immediately (asynchronously) and all outputs to 0, including mid-instruction and mid-T1 wait.
REQ-025 After clear rises, no transition SHALL occur before the first rising clock edge with Start=1.

Verification
REQ-026 ror: IR=32'h43820000 (ror R7,R0,R4), MemReady=1 -> T3 Rout=16'h0001 Yin=1; T4 Rout=16'h0010 ALUop=8 Zlowin=1; T5 Rin=16'h0080 Zlowout=1; then T0.
REQ-027 Memory wait: MemReady low 3 cycles in T1 -> T1 strobes held 4 cycles, IRin asserted exactly once, cycle after MemReady=1.
REQ-028 Unary: IR opcode 10 (not), Ra=2, Rb=5 -> T3 all strobes 0; T4 Rout=16'h0020 ALUop=10; T5 Rin=16'h0004.
REQ-029 Illegal/halt: opcode 5'h0C -> Illegal high one cycle in T3, next state T0, no Rin; opcode 5'h1F -> HALT, Run=0, Start pulses ignored.
REQ-030 Reset mid-op: clear low during T4 -> outputs 0 without clock edge, IDLE after release, Start restarts at T0.
